write_operation: RTL

- Write side of the 8 x 32-bit register file. It owns the eight data registers and drives reg_data0..reg_data7 into the existing read path.
- Accepts a write request with address, data and byte enables. Holds the request for one commit cycle, updates the selected register, then pulses a completion flag.
- Sits beside the read mux in TOP; the register outputs connect directly to the read block inputs.

---
 rtl/write_operation_pkg.sv | 24 ++
 rtl/write_operation_if.sv | 40 ++++
 rtl/write_operation_3_to_8_decoder.sv | 21 ++
 rtl/write_operation.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/write_operation_pkg.sv
// -----------------------------------------------------------------------------
// write_operation_pkg
// Shared constants and types for the register-file write side.
//   DATA_W    : width of each register
//   ADDR_W    : register index width
//   NUM_REGS  : number of registers (2**ADDR_W)
//   BYTE_W    : bits per byte lane
//   NUM_BYTES : byte lanes per register
//   wr_state_e: write FSM encoding (IDLE / COMMIT)
// -----------------------------------------------------------------------------
package write_operation_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 3;
  localparam int NUM_REGS  = 1 << ADDR_W;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = DATA_W / BYTE_W;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } wr_state_e;

endpackage : write_operation_pkg

// File: rtl/write_operation_if.sv
// -----------------------------------------------------------------------------
// write_operation_if
// Write-request handshake between a requester and the register-file write side.
//   we      : write request (requester -> register file)
//   wAddr   : target register index
//   wData   : write data
//   byte_en : byte lane enables, bit i covers wData[8i+7:8i]
//   busy    : a captured write is pending (register file -> requester)
//   wr_done : one-cycle pulse after the register update
// Modports: master = requester, slave = register file write side.
// -----------------------------------------------------------------------------
interface write_operation_if;
  import write_operation_pkg::*;

  logic                 we;
  logic [ADDR_W-1:0]    wAddr;
  logic [DATA_W-1:0]    wData;
  logic [NUM_BYTES-1:0] byte_en;
  logic                 busy;
  logic                 wr_done;

  modport master (
    output we,
    output wAddr,
    output wData,
    output byte_en,
    input  busy,
    input  wr_done
  );

  modport slave (
    input  we,
    input  wAddr,
    input  wData,
    input  byte_en,
    output busy,
    output wr_done
  );

endinterface : write_operation_if

// File: rtl/write_operation_3_to_8_decoder.sv
// -----------------------------------------------------------------------------
// write_operation_3_to_8_decoder
// Purely combinational 3-to-8 one-hot decoder with an enable.
//   addr   : 3-bit index
//   enable : when low every output bit is low
//   onehot : bit addr set when enabled
// -----------------------------------------------------------------------------
module write_operation_3_to_8_decoder (
  input  logic [2:0] addr,
  input  logic       enable,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = 8'h00;
    if (enable) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule : write_operation_3_to_8_decoder

// File: rtl/write_operation.sv
// -----------------------------------------------------------------------------
// write_operation
// Write side of the 8 x 32-bit register file. Owns the data registers and
// drives them straight into the read path.
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset (clears control and registers)
//   wr           : write handshake (slave side): we, wAddr, wData, byte_en in;
//                  busy, wr_done out
//   reg_data0..7 : current register contents, pure register outputs
// A request accepted in IDLE is held for one COMMIT cycle; the selected
// register's enabled bytes update at the end of COMMIT and wr_done pulses in
// the following (IDLE) cycle, which may itself accept the next request.
// -----------------------------------------------------------------------------
module write_operation
  import write_operation_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  write_operation_if.slave  wr,
  output logic [DATA_W-1:0] reg_data0,
  output logic [DATA_W-1:0] reg_data1,
  output logic [DATA_W-1:0] reg_data2,
  output logic [DATA_W-1:0] reg_data3,
  output logic [DATA_W-1:0] reg_data4,
  output logic [DATA_W-1:0] reg_data5,
  output logic [DATA_W-1:0] reg_data6,
  output logic [DATA_W-1:0] reg_data7
);

  // Replace the lanes selected by lane_we, keep the rest of old_word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0]    old_word,
    input logic [DATA_W-1:0]    new_word,
    input logic [NUM_BYTES-1:0] lane_we
  );
    logic [DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (lane_we[i]) begin
        result[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
    return result;
  endfunction

  wr_state_e            state_q;
  wr_state_e            state_d;
  logic                 accept;
  logic                 commit_en;

  logic [ADDR_W-1:0]    hold_addr_p0;
  logic [DATA_W-1:0]    hold_data_p0;
  logic [NUM_BYTES-1:0] hold_be_p0;
  logic                 done_p1;

  logic [NUM_REGS-1:0]  row_sel;
  logic [NUM_BYTES-1:0] byte_we [NUM_REGS];
  logic [DATA_W-1:0]    reg_q   [NUM_REGS];

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic; requests seen while in COMMIT are simply dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr.we) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs decoded from the registered state only
  always_comb begin
    accept    = (state_q == IDLE) && wr.we;
    commit_en = (state_q == COMMIT);
  end

  assign wr.busy    = commit_en;
  assign wr.wr_done = done_p1;

  // Stage p0: request captured on the accepting edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_addr_p0 <= '0;
      hold_data_p0 <= '0;
      hold_be_p0   <= '0;
    end else if (accept) begin
      hold_addr_p0 <= wr.wAddr;
      hold_data_p0 <= wr.wData;
      hold_be_p0   <= wr.byte_en;
    end
  end

  write_operation_3_to_8_decoder u_dec (
    .addr   (hold_addr_p0),
    .enable (commit_en),
    .onehot (row_sel)
  );

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      byte_we[r] = {NUM_BYTES{row_sel[r]}} & hold_be_p0;
    end
  end

  // Stage p1: register array update at the closing edge of COMMIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        reg_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (|byte_we[r]) begin
          reg_q[r] <= merge_bytes(reg_q[r], hold_data_p0, byte_we[r]);
        end
      end
    end
  end

  // Completion flag; a reset during COMMIT clears it before it can rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= commit_en;
    end
  end

  assign reg_data0 = reg_q[0];
  assign reg_data1 = reg_q[1];
  assign reg_data2 = reg_q[2];
  assign reg_data3 = reg_q[3];
  assign reg_data4 = reg_q[4];
  assign reg_data5 = reg_q[5];
  assign reg_data6 = reg_q[6];
  assign reg_data7 = reg_q[7];

endmodule : write_operation
